rx_arbiter: RTL and testbench

Shares the single UART byte receiver between several byte consumers, for example the program loader and the CPU's `,` input instruction. Each consumer raises a level request. The block grants the receiver round-robin, issues the receiver's start strobe, waits for the byte to complete and returns it with a one-cycle acknowledge. A per-requester lock lets one consumer, such as the loader, hold the receiver for a back-to-back burst.

---
 rtl/rx_arbiter.sv | 142 ++++++++++++++
 tb/tb_rx_arbiter.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/rx_arbiter.sv
// Round-robin arbiter sharing one UART byte receiver between NUM_REQ consumers.
// Per-requester lock keeps the grant for back-to-back bursts.
module rx_arbiter #(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned CNT_W   = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    input  logic [NUM_REQ-1:0] lock,
    output logic [NUM_REQ-1:0] gnt,
    output logic [NUM_REQ-1:0] ack,
    output logic [7:0]         data,
    output logic               busy,
    output logic [CNT_W-1:0]   byte_cnt,
    output logic               rx_start,
    input  logic               rx_busy,
    input  logic [7:0]         rx_data
);

    localparam int unsigned PTR_W = $clog2(NUM_REQ);

    localparam logic [1:0] StIdle    = 2'd0;
    localparam logic [1:0] StIssue   = 2'd1;
    localparam logic [1:0] StWait    = 2'd2;
    localparam logic [1:0] StDeliver = 2'd3;

    logic [1:0]         state_q, state_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic [NUM_REQ-1:0] ack_q, ack_d;
    logic [PTR_W-1:0]   owner_q, owner_d;
    logic [PTR_W-1:0]   ptr_q, ptr_d;
    logic [7:0]         data_q, data_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               busy_q, busy_d;
    logic               rx_start_q, rx_start_d;

    logic               pick_valid;
    logic [PTR_W-1:0]   pick_idx;
    logic [PTR_W-1:0]   ptr_next;

    // First requester at or after ptr, searching upward with wrap.
    always_comb begin
        int unsigned idx;
        pick_valid = 1'b0;
        pick_idx   = '0;
        idx        = 0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            idx = (int'(ptr_q) + k) % NUM_REQ;
            if (!pick_valid && req[idx[PTR_W-1:0]]) begin
                pick_valid = 1'b1;
                pick_idx   = idx[PTR_W-1:0];
            end
        end
    end

    assign ptr_next = (owner_q == PTR_W'(NUM_REQ - 1)) ? '0 : owner_q + PTR_W'(1);

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        ack_d   = '0;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (pick_valid) begin
                    gnt_d           = '0;
                    gnt_d[pick_idx] = 1'b1;
                    owner_d         = pick_idx;
                    state_d         = StIssue;
                end
            end
            StIssue: begin
                if (rx_busy) begin
                    state_d = StWait;
                end
            end
            StWait: begin
                if (!rx_busy) begin
                    data_d  = rx_data;
                    cnt_d   = cnt_q + CNT_W'(1);
                    ack_d   = gnt_q;
                    state_d = StDeliver;
                end
            end
            StDeliver: begin
                if (lock[owner_q] && req[owner_q]) begin
                    state_d = StIssue;
                end else begin
                    ptr_d   = ptr_next;
                    gnt_d   = '0;
                    state_d = StIdle;
                end
            end
            default: begin
                gnt_d   = '0;
                state_d = StIdle;
            end
        endcase
    end

    // Status outputs are flopped from the next state so every output is registered.
    always_comb begin
        busy_d     = (state_d != StIdle);
        rx_start_d = (state_d == StIssue);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            gnt_q      <= '0;
            ack_q      <= '0;
            owner_q    <= '0;
            ptr_q      <= '0;
            data_q     <= 8'h00;
            cnt_q      <= '0;
            busy_q     <= 1'b0;
            rx_start_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            ack_q      <= ack_d;
            owner_q    <= owner_d;
            ptr_q      <= ptr_d;
            data_q     <= data_d;
            cnt_q      <= cnt_d;
            busy_q     <= busy_d;
            rx_start_q <= rx_start_d;
        end
    end

    assign gnt      = gnt_q;
    assign ack      = ack_q;
    assign data     = data_q;
    assign busy     = busy_q;
    assign byte_cnt = cnt_q;
    assign rx_start = rx_start_q;

endmodule

// File: tb/tb_rx_arbiter.sv
// Scoreboard bench for rx_arbiter: stimulus pushes expected deliveries, a forked
// monitor pops and compares them whenever ack pulses.
module tb_rx_arbiter;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [1:0] req = 2'b00;
    logic [1:0] lock = 2'b00;
    logic [1:0] gnt;
    logic [1:0] ack;
    logic [7:0] data;
    logic       busy;
    logic [3:0] byte_cnt;
    logic       rx_start;
    logic       rx_busy = 1'b0;
    logic [7:0] rx_data = 8'h00;

    typedef struct packed {
        logic [1:0] ack;
        logic [7:0] data;
        logic [3:0] cnt;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    rx_arbiter #(
        .NUM_REQ(2),
        .CNT_W  (4)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .lock    (lock),
        .gnt     (gnt),
        .ack     (ack),
        .data    (data),
        .busy    (busy),
        .byte_cnt(byte_cnt),
        .rx_start(rx_start),
        .rx_busy (rx_busy),
        .rx_data (rx_data)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic monitor();
        logic prev;
        exp_t e;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev = 1'b0;
            end else begin
                if (ack != 2'b00) begin
                    check("ack_not_back_to_back", {31'd0, prev}, 0);
                    if (exp_q.size() == 0) begin
                        check("ack_unexpected", {30'd0, ack}, 0);
                    end else begin
                        e = exp_q.pop_front();
                        check("ack_owner", {30'd0, ack}, {30'd0, e.ack});
                        check("data", {24'd0, data}, {24'd0, e.data});
                        check("byte_cnt", {28'd0, byte_cnt}, {28'd0, e.cnt});
                    end
                end
                prev = |ack;
            end
        end
    endtask

    // Asserts reset wherever the caller is and checks outputs before any clock edge.
    task automatic do_reset();
        rst     = 1'b1;
        rx_busy = 1'b0;
        req     = 2'b00;
        lock    = 2'b00;
        #1;
        check("rst_gnt", {30'd0, gnt}, 0);
        check("rst_ack", {30'd0, ack}, 0);
        check("rst_data", {24'd0, data}, 0);
        check("rst_busy", {31'd0, busy}, 0);
        check("rst_byte_cnt", {28'd0, byte_cnt}, 0);
        check("rst_rx_start", {31'd0, rx_start}, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wait_start(input logic [1:0] exp_gnt);
        int n;
        n = 0;
        while (!rx_start && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("rx_start_seen", {31'd0, rx_start}, 1);
        check("gnt_at_issue", {30'd0, gnt}, {30'd0, exp_gnt});
        check("busy_at_issue", {31'd0, busy}, 1);
    endtask

    // Receiver model for one byte; req/lock are updated while the DUT sits in WAIT_DONE.
    task automatic serve_byte(input logic [7:0] b, input logic [1:0] exp_gnt,
                              input logic [3:0] exp_cnt, input logic [1:0] req_wd,
                              input logic [1:0] lock_wd, input bit locked_after);
        exp_t e;
        wait_start(exp_gnt);
        @(posedge clk);
        #1 rx_busy = 1'b1;
        @(posedge clk);
        #1;
        req  = req_wd;
        lock = lock_wd;
        check("rx_start_dropped", {31'd0, rx_start}, 0);
        check("gnt_held", {30'd0, gnt}, {30'd0, exp_gnt});
        @(posedge clk);
        @(posedge clk);
        #1;
        rx_busy = 1'b0;
        rx_data = b;
        e.ack   = exp_gnt;
        e.data  = b;
        e.cnt   = exp_cnt;
        exp_q.push_back(e);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        if (locked_after) begin
            check("lock_restart", {31'd0, rx_start}, 1);
            check("lock_gnt_kept", {30'd0, gnt}, {30'd0, exp_gnt});
        end else begin
            check("idle_after", {31'd0, busy}, 0);
            check("gnt_cleared", {30'd0, gnt}, 0);
        end
    endtask

    initial begin
        fork
            monitor();
            begin
                #200000;
                $display("FAIL watchdog: got timeout expected finish");
                $fatal(1, "watchdog expired");
            end
        join_none

        #2;
        // Single request
        do_reset();
        req = 2'b01;
        @(negedge clk);
        check("req_to_start", {31'd0, rx_start}, 1);
        check("req_to_gnt", {30'd0, gnt}, 2'b01);
        serve_byte(8'hA5, 2'b01, 4'd1, 2'b00, 2'b00, 1'b0);

        // Round-robin
        do_reset();
        req = 2'b11;
        serve_byte(8'h11, 2'b01, 4'd1, 2'b11, 2'b00, 1'b0);
        serve_byte(8'h22, 2'b10, 4'd2, 2'b11, 2'b00, 1'b0);
        serve_byte(8'h33, 2'b01, 4'd3, 2'b11, 2'b00, 1'b0);
        serve_byte(8'h44, 2'b10, 4'd4, 2'b00, 2'b00, 1'b0);

        // Locked burst, then lock dropped during the last byte
        do_reset();
        req  = 2'b11;
        lock = 2'b01;
        serve_byte(8'h10, 2'b01, 4'd1, 2'b11, 2'b01, 1'b1);
        serve_byte(8'h11, 2'b01, 4'd2, 2'b11, 2'b01, 1'b1);
        serve_byte(8'h12, 2'b01, 4'd3, 2'b11, 2'b01, 1'b1);
        serve_byte(8'h13, 2'b01, 4'd4, 2'b11, 2'b00, 1'b0);
        serve_byte(8'h14, 2'b10, 4'd5, 2'b00, 2'b00, 1'b0);

        // Withdrawal after grant
        do_reset();
        req = 2'b10;
        serve_byte(8'h7E, 2'b10, 4'd1, 2'b00, 2'b00, 1'b0);

        // Reset mid-transaction
        do_reset();
        req = 2'b01;
        serve_byte(8'h5A, 2'b01, 4'd1, 2'b01, 2'b00, 1'b0);
        wait_start(2'b01);
        @(posedge clk);
        #1 rx_busy = 1'b1;
        @(posedge clk);
        #1;
        check("pre_reset_busy", {31'd0, busy}, 1);
        do_reset();
        req = 2'b11;
        serve_byte(8'h3C, 2'b01, 4'd1, 2'b00, 2'b00, 1'b0);

        // Counter wrap: 17 bytes through a 4-bit counter
        do_reset();
        req = 2'b01;
        for (int i = 0; i < 17; i++) begin
            serve_byte(8'h80 + 8'(i), 2'b01, 4'(i + 1), (i == 16) ? 2'b00 : 2'b01,
                       2'b00, 1'b0);
        end

        repeat (3) @(negedge clk);
        check("scoreboard_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
